// File: rtl/ddc_cmul_pkg.sv
// Shared constants, types and the round/saturate helper for the DDC complex multiplier.
package ddc_cmul_pkg;

  localparam int CMUL_BASE_LAT = 5;
  // Working width for round_sat; holds any P+1-bit value for A_W+B_W up to 62.
  localparam int RS_W = 64;

  typedef struct packed {
    logic signed [RS_W-1:0] val;
    logic                   ovf;
  } rs_t;

  function automatic int p_width(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  // Round half-up by 'shift' bits, then clamp to a signed out_w-bit range.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] value,
                                    input int shift, input int out_w);
    logic signed [RS_W-1:0] rounded;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    rs_t                    r;
    rounded = value;
    if (shift > 0) rounded = value + (64'sd1 <<< (shift - 1));
    rounded = rounded >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    r.ovf = 1'b0;
    r.val = rounded;
    if (rounded > hi) begin
      r.val = hi;
      r.ovf = 1'b1;
    end else if (rounded < lo) begin
      r.val = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ddc_round_sat_stage.sv
// One registered round/saturate stage for a single component (re or im).
module ddc_round_sat_stage
  import ddc_cmul_pkg::*;
#(
  parameter int P     = 35,
  parameter int SHIFT = 15,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    valid_i,
  input  logic signed [P-1:0]     val_i,
  output logic signed [OUT_W-1:0] res_o,
  output logic                    ovf_d_o,
  output logic                    ovf_o
);

  rs_t                    rs;
  logic signed [OUT_W-1:0] res_d;
  logic signed [OUT_W-1:0] res_q;
  logic                    ovf_d;
  logic                    ovf_q;

  always_comb begin
    rs    = round_sat(RS_W'(val_i), SHIFT, OUT_W);
    res_d = rs.val[OUT_W-1:0];
    // Bubbles carry data but must never report an overflow.
    ovf_d = rs.ovf & valid_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
      ovf_q <= 1'b0;
    end else if (ce) begin
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end

  assign res_o   = res_q;
  assign ovf_o   = ovf_q;
  assign ovf_d_o = ovf_d;

endmodule

// File: rtl/ddc_cmul_round_sat.sv
// Pipelined complex multiply A*B or A*conj(B) with half-up rounding, saturation and valid tracking.
module ddc_cmul_round_sat
  import ddc_cmul_pkg::*;
#(
  parameter int A_W          = 18,
  parameter int B_W          = 16,
  parameter int OUT_W        = 16,
  parameter int SHIFT        = 15,
  parameter int EXTRA_STAGES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic                    conj,
  input  logic signed [A_W-1:0]   a_re,
  input  logic signed [A_W-1:0]   a_im,
  input  logic signed [B_W-1:0]   b_re,
  input  logic signed [B_W-1:0]   b_im,
  input  logic                    clr_ovf,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic                    ovf,
  output logic                    ovf_sticky
);

  localparam int PR = A_W + B_W;
  localparam int P  = p_width(A_W, B_W);

  logic signed [A_W-1:0] ar1_q, ai1_q;
  logic signed [B_W-1:0] br1_q, bi1_q;
  logic                  conj1_q, v1_q;
  logic signed [PR-1:0]  rr2_q, ii2_q, ir2_q, ri2_q;
  logic                  conj2_q, v2_q;
  logic signed [PR-1:0]  rr3_q, ii3_q, ir3_q, ri3_q;
  logic                  conj3_q, v3_q;
  logic signed [P-1:0]   re4_d, im4_d, re4_q, im4_q;
  logic                  v4_q, v5_q;
  logic signed [OUT_W-1:0] re5, im5;
  logic                  ovf_re5, ovf_im5, ovf_re_d, ovf_im_d;
  logic                  sticky_d, sticky_q;

  always_comb begin
    re4_d = '0;
    im4_d = '0;
    if (conj3_q) begin
      re4_d = P'(rr3_q) + P'(ii3_q);
      im4_d = P'(ir3_q) - P'(ri3_q);
    end else begin
      re4_d = P'(rr3_q) - P'(ii3_q);
      im4_d = P'(ir3_q) + P'(ri3_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar1_q <= '0; ai1_q <= '0; br1_q <= '0; bi1_q <= '0;
      conj1_q <= 1'b0; v1_q <= 1'b0;
      rr2_q <= '0; ii2_q <= '0; ir2_q <= '0; ri2_q <= '0;
      conj2_q <= 1'b0; v2_q <= 1'b0;
      rr3_q <= '0; ii3_q <= '0; ir3_q <= '0; ri3_q <= '0;
      conj3_q <= 1'b0; v3_q <= 1'b0;
      re4_q <= '0; im4_q <= '0; v4_q <= 1'b0;
      v5_q  <= 1'b0;
    end else if (ce) begin
      ar1_q <= a_re; ai1_q <= a_im; br1_q <= b_re; bi1_q <= b_im;
      conj1_q <= conj; v1_q <= in_valid;
      rr2_q <= PR'(ar1_q) * PR'(br1_q);
      ii2_q <= PR'(ai1_q) * PR'(bi1_q);
      ir2_q <= PR'(ai1_q) * PR'(br1_q);
      ri2_q <= PR'(ar1_q) * PR'(bi1_q);
      conj2_q <= conj1_q; v2_q <= v1_q;
      rr3_q <= rr2_q; ii3_q <= ii2_q; ir3_q <= ir2_q; ri3_q <= ri2_q;
      conj3_q <= conj2_q; v3_q <= v2_q;
      re4_q <= re4_d; im4_q <= im4_d; v4_q <= v3_q;
      v5_q  <= v4_q;
    end
  end

  ddc_round_sat_stage #(.P(P), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs_re (
    .clk(clk), .reset(reset), .ce(ce), .valid_i(v4_q), .val_i(re4_q),
    .res_o(re5), .ovf_d_o(ovf_re_d), .ovf_o(ovf_re5)
  );

  ddc_round_sat_stage #(.P(P), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs_im (
    .clk(clk), .reset(reset), .ce(ce), .valid_i(v4_q), .val_i(im4_q),
    .res_o(im5), .ovf_d_o(ovf_im_d), .ovf_o(ovf_im5)
  );

  // A fresh overflow event beats a simultaneous clear; the clear ignores ce.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_ovf) sticky_d = 1'b0;
    if (ce && (ovf_re_d || ovf_im_d)) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  assign ovf_sticky = sticky_q;

  if (EXTRA_STAGES == 0) begin : g_no_extra
    assign out_valid = v5_q;
    assign out_re    = re5;
    assign out_im    = im5;
    assign ovf       = ovf_re5 | ovf_im5;
  end else begin : g_extra
    logic signed [OUT_W-1:0] dre_q [EXTRA_STAGES];
    logic signed [OUT_W-1:0] dim_q [EXTRA_STAGES];
    logic [EXTRA_STAGES-1:0] dv_q, dovf_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < EXTRA_STAGES; i++) begin
          dre_q[i] <= '0;
          dim_q[i] <= '0;
        end
        dv_q   <= '0;
        dovf_q <= '0;
      end else if (ce) begin
        dre_q[0]  <= re5;
        dim_q[0]  <= im5;
        dv_q[0]   <= v5_q;
        dovf_q[0] <= ovf_re5 | ovf_im5;
        for (int i = 1; i < EXTRA_STAGES; i++) begin
          dre_q[i]  <= dre_q[i-1];
          dim_q[i]  <= dim_q[i-1];
          dv_q[i]   <= dv_q[i-1];
          dovf_q[i] <= dovf_q[i-1];
        end
      end
    end

    assign out_valid = dv_q[EXTRA_STAGES-1];
    assign out_re    = dre_q[EXTRA_STAGES-1];
    assign out_im    = dim_q[EXTRA_STAGES-1];
    assign ovf       = dovf_q[EXTRA_STAGES-1];
  end

endmodule
